duty_ramp: RTL and testbench
============================

Name: duty_ramp

Overview:
- Upstream stage of the 8-bit PWM generator: produces the registered `duty` word the PWM counter compares against.
- Accepts a new target duty over a valid/ready handshake.
- Slews `duty` toward the target by a fixed step once per PWM period (256 clk) for soft-start/soft-stop.
- Updates land at period boundaries, so the PWM never sees a mid-period duty change.

Parameters:
- PERIOD, 256, clk cycles per duty update; must equal the downstream PWM counter period (8-bit wrap).
- STEP, 4, duty increment/decrement per update; legal range 1..255.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  ramp engine enable; low forces duty to 0
- tgt  input  8  requested target duty
- tgt_valid  input  1  tgt is valid this cycle
- tgt_ready  output  1  block can accept tgt; combinational = enable && (state==IDLE)
- duty  output  8  registered duty word to PWM stage
- period_tick  output  1  registered 1-cycle pulse on the last cycle of each period
- at_target  output  1  duty equals latched target (state==IDLE)
- ramping  output  1  state is RAMP_UP or RAMP_DN

Behaviour:
- Reset (rst high at posedge) sets: cnt=0, duty=0x00, target_r=0x00, state=IDLE, period_tick=0. Outputs after reset: tgt_ready=enable, at_target=1, ramping=0.
- Period counter cnt, width clog2(PERIOD):
  - enable=1: counts 0..PERIOD-1, then wraps to 0.
  - period_tick is registered, high exactly in the cycle where cnt==PERIOD-1.
  - enable=0: cnt held at 0, period_tick=0.
- Handshake: transfer occurs when tgt_valid && tgt_ready at a posedge. On transfer, target_r<=tgt, and state goes next cycle to:
  - RAMP_UP if tgt>duty;
  - RAMP_DN if tgt<duty;
  - IDLE if tgt==duty (the transfer still completes).
- While ramping, tgt_ready=0. tgt/tgt_valid are ignored with no queueing; target_r holds.
- FSM states: IDLE, RAMP_UP, RAMP_DN. Steps are taken only at a posedge where period_tick=1:
  - RAMP_UP: sum=duty+STEP (9-bit). If sum>=target_r, duty<=target_r and state<=IDLE; else duty<=sum[7:0].
  - RAMP_DN: if duty<=target_r+STEP (9-bit compare), duty<=target_r and state<=IDLE; else duty<=duty-STEP.
- Saturation: duty never overflows past 0xFF or underflows past 0x00. The final step always clamps exactly to target_r.
- Latency and alignment:
  - A new duty value is visible the cycle after period_tick, i.e. when cnt==0, aligned with the PWM period start.
  - The first step after acceptance happens at the next tick after the transfer cycle.
  - A transfer in the same cycle as a tick does not step in that cycle.
- enable low (any state): next cycle duty=0, target_r=0, state=IDLE, cnt=0.
- enable rising: counting restarts from cnt=0; the first tick arrives PERIOD cycles later.
- rst mid-ramp: same result as reset; any ramp in progress is discarded.
- duty changes only on a tick step, on enable low, or on rst.

Test Plan:
1. rst, enable=1, tgt=0x10 with tgt_valid for 1 cycle -> tgt_ready=0 and ramping=1 from the next cycle; duty=0x04,0x08,0x0C,0x10 after successive ticks 256 clk apart; after the 4th step at_target=1 and tgt_ready=1.
2. From duty=0x00, tgt=0x0A -> duty 0x04, 0x08, then 0x0A (clamped, not 0x0C); IDLE after 3 ticks.
3. From duty=0x10, tgt=0x03 -> duty 0x0C, 0x08, 0x04, 0x03; no underflow. From duty=0xFC, tgt=0xFF -> single step to 0xFF.
4. During RAMP_UP toward 0x10, assert tgt_valid with tgt=0x80 -> tgt_ready stays 0, target_r stays 0x10, ramp ends at 0x10.
5. In IDLE with duty=0x20, send tgt=0x20 -> transfer occurs, state stays IDLE, ramping never asserts, duty unchanged across ticks.
6. Mid-ramp at duty=0x08: drop enable for 1 cycle -> duty=0x00, at_target=1, period_tick absent; re-enable -> first tick 256 clk later. Repeat with rst instead of enable -> same response.

Source files
------------

// File: rtl/duty_ramp.sv
// Duty-word slew stage feeding the 8-bit PWM comparator: accepts a target duty and
// walks the registered duty toward it by STEP once per PWM period.
module duty_ramp #(
  parameter int PERIOD = 256,
  parameter int STEP   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] tgt,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  output logic [7:0] duty,
  output logic       period_tick,
  output logic       at_target,
  output logic       ramping
);

  localparam int             CW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(PERIOD - 1);
  localparam logic [8:0]     STEP9    = 9'(STEP);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic [7:0]    duty_q, duty_d;
  logic [7:0]    target_q, target_d;
  logic [8:0]    sum_up;
  logic [8:0]    lim_dn;

  // Tick is registered so it is high exactly while cnt_q sits at the last count.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (enable) begin
      cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      tick_d = (cnt_d == CNT_LAST);
    end
  end

  assign sum_up = {1'b0, duty_q} + STEP9;
  assign lim_dn = {1'b0, target_q} + STEP9;

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    if (!enable) begin
      state_d  = IDLE;
      duty_d   = 8'h00;
      target_d = 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (tgt_valid) begin
            target_d = tgt;
            if (tgt > duty_q)      state_d = RAMP_UP;
            else if (tgt < duty_q) state_d = RAMP_DN;
            else                   state_d = IDLE;
          end
        end
        RAMP_UP: begin
          if (tick_q) begin
            // Clamp on the last step so duty lands exactly on target and never wraps.
            if (sum_up >= {1'b0, target_q}) begin
              duty_d  = target_q;
              state_d = IDLE;
            end else begin
              duty_d = sum_up[7:0];
            end
          end
        end
        RAMP_DN: begin
          if (tick_q) begin
            if ({1'b0, duty_q} <= lim_dn) begin
              duty_d  = target_q;
              state_d = IDLE;
            end else begin
              duty_d = duty_q - STEP9[7:0];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      duty_q   <= 8'h00;
      target_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      duty_q   <= duty_d;
      target_q <= target_d;
    end
  end

  assign tgt_ready   = enable && (state_q == IDLE);
  assign duty        = duty_q;
  assign period_tick = tick_q;
  assign at_target   = (state_q == IDLE);
  assign ramping     = (state_q == RAMP_UP) || (state_q == RAMP_DN);

endmodule

// File: tb/tb_duty_ramp.sv
// Bench for duty_ramp: directed soft-start/stop scenarios plus randomized traffic,
// all compared every cycle against an arithmetic model of duty, target and period.
module tb_duty_ramp;
  localparam int PERIOD = 256;
  localparam int STEP   = 4;

  logic       clk = 1'b0;
  logic       rst, enable, tgt_valid;
  logic [7:0] tgt;
  logic       tgt_ready, period_tick, at_target, ramping;
  logic [7:0] duty;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: ramping is simply "duty differs from latched target"; period position is a counter.
  int m_duty = 0;
  int m_target = 0;
  int m_cnt = 0;

  duty_ramp #(.PERIOD(PERIOD), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .tgt(tgt), .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready), .duty(duty), .period_tick(period_tick),
    .at_target(at_target), .ramping(ramping)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst || !enable) begin
      m_cnt = 0; m_duty = 0; m_target = 0;
    end else begin
      if (m_duty == m_target) begin
        if (tgt_valid) m_target = int'(tgt);
      end else if (m_cnt == PERIOD - 1) begin
        if (m_target > m_duty) m_duty = (m_duty + STEP > m_target) ? m_target : m_duty + STEP;
        else                   m_duty = (m_duty - STEP < m_target) ? m_target : m_duty - STEP;
      end
      m_cnt = (m_cnt + 1) % PERIOD;
    end
  end

  always @(posedge clk)
    if (!rst && tgt_valid && tgt_ready)
      $display("XFER t=%0t tgt=%02h duty=%02h", $time, tgt, duty);

  always @(negedge clk) begin
    if (chk_en) begin
      check("duty", 32'(duty), 32'(m_duty));
      check("period_tick", 32'(period_tick), 32'(m_cnt == PERIOD - 1));
      check("tgt_ready", 32'(tgt_ready), 32'(enable && (m_duty == m_target)));
      check("at_target", 32'(at_target), 32'(m_duty == m_target));
      check("ramping", 32'(ramping), 32'(m_duty != m_target));
    end
  end

  task automatic send(input logic [7:0] v);
    @(posedge clk); #1;
    tgt = v; tgt_valid = 1'b1;
    @(posedge clk); #1;
    tgt_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  // Returns at the negedge just after the step that follows the next tick.
  task automatic step_wait();
    int n = 0;
    @(negedge clk);
    while (period_tick !== 1'b1 && n < PERIOD + 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= PERIOD + 10) begin
      checks++; errors++;
      $display("FAIL tick_timeout t=%0t actual=none required=tick", $time);
    end
    @(negedge clk);
  endtask

  task automatic count_to_tick(input string name);
    int n = 1;
    while (period_tick !== 1'b1 && n < PERIOD + 10) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n), 32'(PERIOD));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp3[4] = '{12, 8, 4, 3};
    int exp2[3] = '{4, 8, 10};
    int n;
    rst = 1'b1; enable = 1'b0; tgt = 8'h00; tgt_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 enable = 1'b1;
    @(posedge clk); #1 rst = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    check("rst_duty", 32'(duty), 32'h00);
    check("rst_at_target", 32'(at_target), 32'h1);
    check("rst_ramping", 32'(ramping), 32'h0);
    check("rst_ready", 32'(tgt_ready), 32'h1);

    // Soft start to 0x10, with an ignored new target mid-ramp.
    send(8'h10);
    @(negedge clk);
    check("t1_ramping", 32'(ramping), 32'h1);
    check("t1_ready", 32'(tgt_ready), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      step_wait();
      check("t1_duty", 32'(duty), 32'(4 * k));
      @(posedge clk); #1;
      if (k == 1) begin tgt = 8'h80; tgt_valid = 1'b1; end
      if (k == 3) tgt_valid = 1'b0;
    end
    check("t1_at_target", 32'(at_target), 32'h1);
    check("t1_ready", 32'(tgt_ready), 32'h1);

    // Same-value target: transfer completes, no ramp.
    send(8'h10);
    @(negedge clk);
    check("t5_ramping", 32'(ramping), 32'h0);
    step_wait();
    check("t5_duty", 32'(duty), 32'h10);

    // Ramp down with final clamp.
    send(8'h03);
    for (int k = 0; k < 4; k++) begin
      step_wait();
      check("t3_duty", 32'(duty), 32'(exp3[k]));
    end
    check("t3_at_target", 32'(at_target), 32'h1);

    // From zero to 0x0A: clamp on third step.
    do_reset();
    send(8'h0A);
    for (int k = 0; k < 3; k++) begin
      step_wait();
      check("t2_duty", 32'(duty), 32'(exp2[k]));
    end
    check("t2_at_target", 32'(at_target), 32'h1);

    // Long ramp to 0xFC then a single clamped step to 0xFF.
    send(8'hFC);
    n = 0;
    while (at_target !== 1'b1 && n < 70 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    check("t3b_duty_fc", 32'(duty), 32'hFC);
    send(8'hFF);
    step_wait();
    check("t3b_duty_ff", 32'(duty), 32'hFF);
    check("t3b_at_target", 32'(at_target), 32'h1);

    // Enable drop mid-ramp.
    do_reset();
    send(8'h40);
    step_wait(); step_wait();
    check("t6_duty_08", 32'(duty), 32'h08);
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); #1 enable = 1'b1;
    @(negedge clk);
    check("t6_duty_0", 32'(duty), 32'h00);
    check("t6_at_target", 32'(at_target), 32'h1);
    check("t6_tick", 32'(period_tick), 32'h0);
    count_to_tick("t6_first_tick");
    @(negedge clk);
    check("t6_duty_hold", 32'(duty), 32'h00);

    // Same with rst.
    send(8'h40);
    step_wait(); step_wait();
    check("t6r_duty_08", 32'(duty), 32'h08);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6r_duty_0", 32'(duty), 32'h00);
    check("t6r_at_target", 32'(at_target), 32'h1);
    check("t6r_tick", 32'(period_tick), 32'h0);
    count_to_tick("t6r_first_tick");
    @(negedge clk);
    check("t6r_duty_hold", 32'(duty), 32'h00);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int t = 0; t < 40; t++) begin
      int r = $urandom_range(0, 99);
      int hold = $urandom_range(50, 900);
      logic [7:0] v = 8'($urandom);
      if (r < 6) begin
        @(posedge clk); #1 enable = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 enable = 1'b1;
      end else if (r < 9) begin
        do_reset();
      end
      send(v);
      for (int c = 0; c < hold; c++) begin
        @(posedge clk); #1;
        tgt_valid = ($urandom_range(0, 19) == 0);
        tgt = 8'($urandom);
      end
      tgt_valid = 1'b0;
      $display("TXN %0d tgt=%02h duty=%02h ramping=%0b", t, v, duty, ramping);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
